// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port among NUM_PORTS line requesters.
// Define PMEM_ARB_BYPASS_EN for a combinational response path (no RESP state).
module pmem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  output logic                             pmem_read,
  output logic                             pmem_write
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef PMEM_ARB_BYPASS_EN
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
`endif

  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          grant;
  logic [PW-1:0]          sel_idx;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          rr_next;
  logic                   any_req;
  logic [NUM_PORTS-1:0]   req_any;
  logic [NUM_PORTS-1:0]   grant_onehot;

  assign req_any = req_read | req_write;
  assign rr_next = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

  // First requester found scanning upward from rr_ptr, wrapping at NUM_PORTS.
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!any_req && req_any[cand]) begin
        any_req = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      grant_onehot[i] = (grant == PW'(i));
  end

`ifdef PMEM_ARB_BYPASS_EN
  assign req_resp  = (state == BUSY && pmem_resp) ? grant_onehot : '0;
  assign req_rdata = pmem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
`ifndef PMEM_ARB_BYPASS_EN
      req_rdata    <= '0;
      req_resp     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant        <= sel_idx;
            pmem_address <= req_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pmem_wdata   <= req_wdata[sel_idx*LINE_WIDTH +: LINE_WIDTH];
            // Write takes precedence when a port raises both.
            pmem_write   <= req_write[sel_idx];
            pmem_read    <= ~req_write[sel_idx];
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
`ifdef PMEM_ARB_BYPASS_EN
            rr_ptr     <= rr_next;
            state      <= IDLE;
`else
            req_rdata  <= pmem_rdata;
            req_resp   <= grant_onehot;
            state      <= RESP;
`endif
          end
        end
`ifndef PMEM_ARB_BYPASS_EN
        RESP: begin
          req_resp <= '0;
          rr_ptr   <= rr_next;
          state    <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a 2-port and a 3-port instance checked against a
// round-robin transaction model; honours PMEM_ARB_BYPASS_EN for response timing.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel3;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  // Model state: one pending transaction per port.
  logic [2:0]   pend;
  logic [2:0]   opw;
  logic [31:0]  b_addr [3];
  logic [255:0] b_wdata [3];
  int           mptr;
  int           nports;
  int           checks;
  int           failures;

  logic [2:0] b_read, b_write;
  assign b_read  = pend & ~opw;
  assign b_write = pend & opw;

  logic [1:0]   d2_read, d2_write, d2_resp;
  logic [63:0]  d2_addr;
  logic [511:0] d2_wdata;
  logic [255:0] d2_rdata, d2_pwdata;
  logic [31:0]  d2_paddr;
  logic         d2_pread, d2_pwrite;

  logic [2:0]   d3_read, d3_write, d3_resp;
  logic [95:0]  d3_addr;
  logic [767:0] d3_wdata;
  logic [255:0] d3_rdata, d3_pwdata;
  logic [31:0]  d3_paddr;
  logic         d3_pread, d3_pwrite;

  assign d2_read  = sel3 ? 2'b00 : b_read[1:0];
  assign d2_write = sel3 ? 2'b00 : b_write[1:0];
  assign d2_addr  = {b_addr[1], b_addr[0]};
  assign d2_wdata = {b_wdata[1], b_wdata[0]};
  assign d3_read  = sel3 ? b_read : 3'b000;
  assign d3_write = sel3 ? b_write : 3'b000;
  assign d3_addr  = {b_addr[2], b_addr[1], b_addr[0]};
  assign d3_wdata = {b_wdata[2], b_wdata[1], b_wdata[0]};

  pmem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(256)) dut2 (
    .clk(clk), .rst(rst), .req_read(d2_read), .req_write(d2_write),
    .req_address(d2_addr), .req_wdata(d2_wdata), .req_rdata(d2_rdata),
    .req_resp(d2_resp), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_address(d2_paddr), .pmem_wdata(d2_pwdata),
    .pmem_read(d2_pread), .pmem_write(d2_pwrite)
  );

  pmem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .LINE_WIDTH(256)) dut3 (
    .clk(clk), .rst(rst), .req_read(d3_read), .req_write(d3_write),
    .req_address(d3_addr), .req_wdata(d3_wdata), .req_rdata(d3_rdata),
    .req_resp(d3_resp), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_address(d3_paddr), .pmem_wdata(d3_pwdata),
    .pmem_read(d3_pread), .pmem_write(d3_pwrite)
  );

  logic         o_read, o_write;
  logic [2:0]   o_resp;
  logic [31:0]  o_addr;
  logic [255:0] o_wdata, o_rdata;
  assign o_read  = sel3 ? d3_pread  : d2_pread;
  assign o_write = sel3 ? d3_pwrite : d2_pwrite;
  assign o_resp  = sel3 ? d3_resp   : {1'b0, d2_resp};
  assign o_addr  = sel3 ? d3_paddr  : d2_paddr;
  assign o_wdata = sel3 ? d3_pwdata : d2_pwdata;
  assign o_rdata = sel3 ? d3_rdata  : d2_rdata;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2:0] onehot(input int w);
    logic [2:0] v;
    v = 3'b001;
    return v << w;
  endfunction

  task automatic new_req(input int p, input bit w, input logic [31:0] a, input logic [255:0] d);
    pend[p]    = 1'b1;
    opw[p]     = w;
    b_addr[p]  = a;
    b_wdata[p] = d;
  endtask

  task automatic check_busy(input bit eop, input logic [31:0] ea, input logic [255:0] ed);
    chk("pmem_read", o_read, !eop);
    chk("pmem_write", o_write, eop);
    chk("pmem_address", o_addr, ea);
    chk("pmem_wdata", o_wdata, ed);
    chk("resp_early", o_resp, 3'b000);
  endtask

  // Entered in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_txn(input int k, input bit mutate, input logic [255:0] rd);
    int w;
    bit eop;
    logic [31:0] ea;
    logic [255:0] ed;
    w = -1;
    for (int i = 0; i < nports; i++) begin
      int c;
      c = (mptr + i) % nports;
      if (w < 0 && pend[c]) w = c;
    end
    if (w < 0) begin
      tick();
      chk("idle_strobe", {o_read, o_write}, 2'b00);
      return;
    end
    eop = opw[w];
    ea  = b_addr[w];
    ed  = b_wdata[w];
    tick();
    check_busy(eop, ea, ed);
    if (mutate) begin
      b_addr[w]  = ~ea;
      b_wdata[w] = ~ed;
    end
    for (int j = 0; j < k; j++) begin
      tick();
      check_busy(eop, ea, ed);
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
`ifdef PMEM_ARB_BYPASS_EN
    #1;
    chk("req_resp", o_resp, onehot(w));
    chk("req_rdata", o_rdata, rd);
    tick();
`else
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    #1;
    chk("req_resp", o_resp, onehot(w));
    chk("req_rdata", o_rdata, rd);
    chk("resp_strobe", {o_read, o_write}, 2'b00);
    tick();
`endif
    pmem_resp = 1'b0;
    pend[w]   = 1'b0;
    mptr      = (w + 1) % nports;
    #1;
    chk("resp_done", o_resp, 3'b000);
    chk("idle_strobe", {o_read, o_write}, 2'b00);
  endtask

  task automatic rand_phase(input int iters);
    for (int n = 0; n < iters; n++) begin
      for (int p = 0; p < nports; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1)
          new_req(p, $urandom_range(0, 1) == 1, $urandom, rand_line());
      run_txn($urandom_range(0, 3), 1'b0, rand_line());
    end
  endtask

  initial begin
    checks = 0; failures = 0; mptr = 0; nports = 2;
    rst = 1'b1; sel3 = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    pend = '0; opw = '0;
    for (int p = 0; p < 3; p++) begin b_addr[p] = '0; b_wdata[p] = '0; end
    repeat (3) tick();
    chk("rst_read", o_read, 1'b0);
    chk("rst_write", o_write, 1'b0);
    chk("rst_resp", o_resp, 3'b000);
    chk("rst_addr", o_addr, 32'h0);
    chk("rst_wdata", o_wdata, 256'h0);
    chk("rst_rdata", o_rdata, 256'h0);
    chk("rst3_resp", d3_resp, 3'b000);
    rst = 1'b0;

    // Port0 read, memory answers three cycles after the strobe appears.
    new_req(0, 1'b0, 32'h0000_0040, rand_line());
    run_txn(3, 1'b0, {32{8'hA5}});

    // Simultaneous requests: 0 then 1, pointer back at 0 afterwards.
    new_req(0, 1'b0, 32'h0000_0100, rand_line());
    new_req(1, 1'b1, 32'h0000_0200, rand_line());
    run_txn(1, 1'b0, rand_line());
    run_txn(2, 1'b0, rand_line());
    new_req(0, 1'b1, 32'h0000_0300, rand_line());
    new_req(1, 1'b0, 32'h0000_0400, rand_line());
    run_txn(0, 1'b0, rand_line());
    run_txn(0, 1'b0, rand_line());

    // Port1 streams writes while port0 reads.
    new_req(1, 1'b1, 32'h0000_1100, rand_line());
    run_txn(1, 1'b0, rand_line());
    for (int n = 0; n < 4; n++) begin
      if (!pend[0]) new_req(0, 1'b0, 32'h0000_2000 + n, rand_line());
      if (!pend[1]) new_req(1, 1'b1, 32'h0000_3000 + n, rand_line());
      run_txn(1, 1'b0, rand_line());
    end
    if (pend[1]) run_txn(0, 1'b0, rand_line());
    if (pend[0]) run_txn(0, 1'b0, rand_line());

    // Latched write address/data survive requester changes mid-transaction.
    new_req(0, 1'b1, 32'h0000_1000, {8{32'hDEAD_BEEF}});
    run_txn(4, 1'b1, rand_line());

    // Reset during BUSY with the pointer at 1.
    new_req(1, 1'b0, 32'h0000_5000, rand_line());
    tick();
    chk("pre_rst_read", o_read, 1'b1);
    rst = 1'b1; pend = '0;
    tick();
    rst = 1'b0;
    chk("midrst_read", o_read, 1'b0);
    chk("midrst_resp", o_resp, 3'b000);
    chk("midrst_addr", o_addr, 32'h0);
    mptr = 0;
    pmem_resp = 1'b1;
    #1;
    chk("stray_resp_comb", o_resp, 3'b000);
    tick();
    pmem_resp = 1'b0;
    chk("stray_resp", o_resp, 3'b000);
    chk("stray_strobe", {o_read, o_write}, 2'b00);
    tick();
    chk("stray_resp2", o_resp, 3'b000);
    new_req(0, 1'b0, 32'h0000_6000, rand_line());
    new_req(1, 1'b0, 32'h0000_7000, rand_line());
    run_txn(2, 1'b0, rand_line());
    run_txn(1, 1'b0, rand_line());

    rand_phase(40);

    // Three ports, all requesting continuously: 0,1,2,0.
    pend = '0;
    #1;
    sel3 = 1'b1; nports = 3; mptr = 0;
    for (int p = 0; p < 3; p++) new_req(p, p == 1, 32'h0000_8000 + 32'(p) * 32'h100, rand_line());
    for (int n = 0; n < 4; n++) begin
      run_txn(1, 1'b0, rand_line());
      for (int p = 0; p < 3; p++)
        if (!pend[p]) new_req(p, 1'b0, 32'h0000_9000 + 32'(n * 16 + p), rand_line());
    end
    rand_phase(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
